// File: rtl/pc_ras_unit.sv
// Program counter with next-PC select and a circular return-address stack.
// JAL pushes its link address; RET pops it and scores the prediction against rdat1.
module pc_ras_unit #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4,
    parameter int          CNT_W     = 16
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         ihit,
    input  logic                         dhit,
    input  logic                         pc_en,
    input  logic [2:0]                   PCSrc,
    input  logic [31:0]                  rdat1,
    input  logic [15:0]                  immediate,
    input  logic [25:0]                  immediate26,
    input  logic                         ras_flush,
    output logic [31:0]                  imemaddr,
    output logic [31:0]                  pc_plus4,
    output logic [31:0]                  ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic [CNT_W-1:0]             ras_hit_cnt,
    output logic [CNT_W-1:0]             ras_miss_cnt,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] SRC_BR  = 3'd1;
    localparam logic [2:0] SRC_J   = 3'd2;
    localparam logic [2:0] SRC_JR  = 3'd3;
    localparam logic [2:0] SRC_JAL = 3'd4;
    localparam logic [2:0] SRC_RET = 3'd5;

    logic [31:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] tp;
    logic [PW-1:0] tp_inc;
    logic [PW-1:0] tp_dec;
    logic [31:0]   br_off;
    logic [31:0]   j_tgt;
    logic [31:0]   next_pc;
    logic          advance;
    logic          do_push;
    logic          do_pop;
    logic          ras_full;
    logic          ras_empty;
    logic          hit_sat;
    logic          miss_sat;

    assign pc_plus4  = imemaddr + 32'd4;
    assign advance   = pc_en & ihit & ~dhit;
    // flush wins over a same-cycle push/pop; the PC itself still advances
    assign do_push   = advance & ~ras_flush & (PCSrc == SRC_JAL);
    assign do_pop    = advance & ~ras_flush & (PCSrc == SRC_RET);
    assign tp_inc    = tp + PW'(1);
    assign tp_dec    = tp - PW'(1);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign ras_empty = (ras_count == '0);
    assign hit_sat   = &ras_hit_cnt;
    assign miss_sat  = &ras_miss_cnt;
    assign ras_top   = ras_empty ? 32'd0 : ras_mem[tp];
    assign br_off    = {{14{immediate[15]}}, immediate, 2'b00};
    assign j_tgt     = {pc_plus4[31:28], immediate26, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            SRC_BR:  next_pc = pc_plus4 + br_off;
            SRC_J:   next_pc = j_tgt;
            SRC_JR:  next_pc = rdat1;
            SRC_JAL: next_pc = j_tgt;
            SRC_RET: next_pc = rdat1;
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            imemaddr      <= PC_INIT;
            tp            <= '0;
            ras_count     <= '0;
            ras_hit_cnt   <= '0;
            ras_miss_cnt  <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= 32'd0;
            end
        end else begin
            ras_underflow <= 1'b0;
            if (advance) begin
                imemaddr <= next_pc;
            end
            if (ras_flush) begin
                tp        <= '0;
                ras_count <= '0;
            end else if (do_push) begin
                // when full the write lands on the oldest slot, so count stays put
                ras_mem[tp_inc] <= pc_plus4;
                tp              <= tp_inc;
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CW'(1);
                end
            end else if (do_pop) begin
                if (ras_empty) begin
                    ras_underflow <= 1'b1;
                    if (!miss_sat) ras_miss_cnt <= ras_miss_cnt + CNT_W'(1);
                end else begin
                    if (ras_mem[tp] == rdat1) begin
                        if (!hit_sat) ras_hit_cnt <= ras_hit_cnt + CNT_W'(1);
                    end else begin
                        if (!miss_sat) ras_miss_cnt <= ras_miss_cnt + CNT_W'(1);
                    end
                    tp        <= tp_dec;
                    ras_count <= ras_count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: directed vector table, reset/stall corner sequences,
// then random traffic checked against a queue-based return-stack model.
module tb_pc_ras_unit;

    localparam logic [31:0] PC_INIT   = 32'h0000_0000;
    localparam int          RAS_DEPTH = 4;
    localparam int          CNT_W     = 4;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, pc_en, ras_flush;
    logic [2:0]  PCSrc;
    logic [31:0] rdat1;
    logic [15:0] immediate;
    logic [25:0] immediate26;
    logic [31:0] imemaddr, pc_plus4, ras_top;
    logic [2:0]  ras_count;
    logic [CNT_W-1:0] ras_hit_cnt, ras_miss_cnt;
    logic        ras_overflow, ras_underflow;

    pc_ras_unit #(.PC_INIT(PC_INIT), .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .pc_en(pc_en),
        .PCSrc(PCSrc), .rdat1(rdat1), .immediate(immediate), .immediate26(immediate26),
        .ras_flush(ras_flush), .imemaddr(imemaddr), .pc_plus4(pc_plus4), .ras_top(ras_top),
        .ras_count(ras_count), .ras_hit_cnt(ras_hit_cnt), .ras_miss_cnt(ras_miss_cnt),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: the stack is a bounded queue, newest at the back
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    int          m_hit, m_miss;
    logic        m_ovf, m_unf;

    typedef struct {
        logic [2:0]  src;
        logic        ih, dh, en, fl;
        logic [31:0] rd;
        logic [15:0] imm;
        logic [25:0] imm26;
        logic [31:0] e_pc;
        int          e_cnt;
        logic [31:0] e_top;
        int          e_hit, e_miss;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] src, logic ih, logic dh, logic en, logic fl,
                                logic [31:0] rd, logic [15:0] imm, logic [25:0] imm26,
                                logic [31:0] e_pc, int e_cnt, logic [31:0] e_top,
                                int e_hit, int e_miss, logic e_ovf, logic e_unf);
        vec_t v;
        v.src = src; v.ih = ih; v.dh = dh; v.en = en; v.fl = fl;
        v.rd = rd; v.imm = imm; v.imm26 = imm26;
        v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_top = e_top;
        v.e_hit = e_hit; v.e_miss = e_miss; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = PC_INIT;
        m_q.delete();
        m_hit = 0; m_miss = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_edge();
        logic        adv;
        logic [31:0] base, tgt, v;
        adv  = pc_en & ihit & ~dhit;
        base = m_pc + 32'd4;
        m_unf = 1'b0;
        if (ras_flush) m_q.delete();
        if (adv) begin
            case (PCSrc)
                3'd1:    tgt = base + 32'(signed'(immediate)) * 4;
                3'd2, 3'd4: tgt = {base[31:28], immediate26, 2'b00};
                3'd3, 3'd5: tgt = rdat1;
                default: tgt = base;
            endcase
            if (!ras_flush && PCSrc == 3'd4) begin
                m_q.push_back(base);
                if (m_q.size() > RAS_DEPTH) begin
                    void'(m_q.pop_front());
                    m_ovf = 1'b1;
                end
            end
            if (!ras_flush && PCSrc == 3'd5) begin
                if (m_q.size() == 0) begin
                    m_unf = 1'b1;
                    if (m_miss < CNT_MAX) m_miss++;
                end else begin
                    v = m_q.pop_back();
                    if (v == rdat1) begin
                        if (m_hit < CNT_MAX) m_hit++;
                    end else if (m_miss < CNT_MAX) m_miss++;
                end
            end
            m_pc = tgt;
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".pc"},    imemaddr, m_pc);
        chk({tag, ".pc4"},   pc_plus4, m_pc + 32'd4);
        chk({tag, ".count"}, 32'(ras_count), 32'(m_q.size()));
        chk({tag, ".top"},   ras_top, (m_q.size() > 0) ? m_q[$] : 32'd0);
        chk({tag, ".hit"},   32'(ras_hit_cnt), 32'(m_hit));
        chk({tag, ".miss"},  32'(ras_miss_cnt), 32'(m_miss));
        chk({tag, ".ovf"},   32'(ras_overflow), 32'(m_ovf));
        chk({tag, ".unf"},   32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge CLK);
        #1;
        compare_model(tag);
    endtask

    task automatic drive(input logic [2:0] src, input logic ih, input logic dh, input logic en,
                         input logic fl, input logic [31:0] rd, input logic [15:0] imm,
                         input logic [25:0] imm26);
        PCSrc = src; ihit = ih; dhit = dh; pc_en = en; ras_flush = fl;
        rdat1 = rd; immediate = imm; immediate26 = imm26;
    endtask

    initial begin
        nRST = 1'b0;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 26'd0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset.pc",    imemaddr, 32'h0);
        chk("reset.count", 32'(ras_count), 32'd0);
        chk("reset.top",   ras_top, 32'd0);
        chk("reset.ovf",   32'(ras_overflow), 32'd0);
        chk("reset.unf",   32'(ras_underflow), 32'd0);
        chk("reset.hit",   32'(ras_hit_cnt), 32'd0);
        chk("reset.miss",  32'(ras_miss_cnt), 32'd0);
        #3 nRST = 1'b1;

        //        src  ih dh en fl rdat1        imm       imm26      pc        cnt top        hit miss ovf unf
        tbl.push_back(mk(3'd0, 1, 0, 1, 0, 32'h0,   16'h0,    26'h0,  32'h004, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd0, 1, 0, 1, 0, 32'h0,   16'h0,    26'h0,  32'h008, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd0, 1, 0, 1, 0, 32'h0,   16'h0,    26'h0,  32'h00C, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd0, 0, 0, 1, 0, 32'h0,   16'h0,    26'h0,  32'h00C, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd0, 0, 0, 1, 0, 32'h0,   16'h0,    26'h0,  32'h00C, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd0, 1, 0, 1, 0, 32'h0,   16'h0,    26'h0,  32'h010, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd1, 1, 0, 1, 0, 32'h0,   16'hFFFC, 26'h0,  32'h004, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd2, 1, 0, 1, 0, 32'h0,   16'h0,    26'h40, 32'h100, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd0, 1, 1, 1, 0, 32'h0,   16'h0,    26'h0,  32'h100, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd2, 1, 0, 1, 0, 32'h0,   16'h0,    26'h8,  32'h020, 0, 32'h0,   0, 0, 0, 0));
        tbl.push_back(mk(3'd4, 1, 0, 1, 0, 32'h0,   16'h0,    26'h80, 32'h200, 1, 32'h24,  0, 0, 0, 0));
        tbl.push_back(mk(3'd5, 1, 0, 1, 0, 32'h24,  16'h0,    26'h0,  32'h024, 0, 32'h0,   1, 0, 0, 0));
        tbl.push_back(mk(3'd5, 1, 0, 1, 0, 32'h50,  16'h0,    26'h0,  32'h050, 0, 32'h0,   1, 1, 0, 1));
        tbl.push_back(mk(3'd0, 1, 0, 1, 0, 32'h0,   16'h0,    26'h0,  32'h054, 0, 32'h0,   1, 1, 0, 0));
        tbl.push_back(mk(3'd2, 1, 0, 1, 0, 32'h0,   16'h0,    26'h8,  32'h020, 0, 32'h0,   1, 1, 0, 0));
        tbl.push_back(mk(3'd4, 1, 0, 1, 0, 32'h0,   16'h0,    26'h80, 32'h200, 1, 32'h24,  1, 1, 0, 0));
        tbl.push_back(mk(3'd5, 1, 0, 1, 0, 32'h28,  16'h0,    26'h0,  32'h028, 0, 32'h0,   1, 2, 0, 0));
        tbl.push_back(mk(3'd4, 1, 0, 1, 0, 32'h0,   16'h0,    26'h10, 32'h040, 1, 32'h2C,  1, 2, 0, 0));
        tbl.push_back(mk(3'd4, 1, 0, 1, 0, 32'h0,   16'h0,    26'h20, 32'h080, 2, 32'h44,  1, 2, 0, 0));
        tbl.push_back(mk(3'd4, 1, 0, 1, 0, 32'h0,   16'h0,    26'h30, 32'h0C0, 3, 32'h84,  1, 2, 0, 0));
        tbl.push_back(mk(3'd4, 1, 0, 1, 0, 32'h0,   16'h0,    26'h40, 32'h100, 4, 32'hC4,  1, 2, 0, 0));
        tbl.push_back(mk(3'd4, 1, 0, 1, 0, 32'h0,   16'h0,    26'h50, 32'h140, 4, 32'h104, 1, 2, 1, 0));
        tbl.push_back(mk(3'd5, 1, 0, 1, 0, 32'h104, 16'h0,    26'h0,  32'h104, 3, 32'hC4,  2, 2, 1, 0));
        tbl.push_back(mk(3'd5, 1, 0, 1, 0, 32'hC4,  16'h0,    26'h0,  32'h0C4, 2, 32'h84,  3, 2, 1, 0));
        tbl.push_back(mk(3'd5, 1, 0, 1, 0, 32'h84,  16'h0,    26'h0,  32'h084, 1, 32'h44,  4, 2, 1, 0));
        tbl.push_back(mk(3'd5, 1, 0, 1, 0, 32'h44,  16'h0,    26'h0,  32'h044, 0, 32'h0,   5, 2, 1, 0));
        tbl.push_back(mk(3'd5, 1, 0, 1, 0, 32'h2C,  16'h0,    26'h0,  32'h02C, 0, 32'h0,   5, 3, 1, 1));
        tbl.push_back(mk(3'd4, 1, 0, 1, 1, 32'h0,   16'h0,    26'h80, 32'h200, 0, 32'h0,   5, 3, 1, 0));
        tbl.push_back(mk(3'd4, 1, 0, 0, 0, 32'h0,   16'h0,    26'h10, 32'h200, 0, 32'h0,   5, 3, 1, 0));
        tbl.push_back(mk(3'd4, 1, 1, 1, 0, 32'h0,   16'h0,    26'h10, 32'h200, 0, 32'h0,   5, 3, 1, 0));
        tbl.push_back(mk(3'd4, 1, 0, 1, 0, 32'h0,   16'h0,    26'h10, 32'h040, 1, 32'h204, 5, 3, 1, 0));
        tbl.push_back(mk(3'd5, 0, 0, 1, 0, 32'h204, 16'h0,    26'h0,  32'h040, 1, 32'h204, 5, 3, 1, 0));
        tbl.push_back(mk(3'd5, 1, 0, 1, 0, 32'h204, 16'h0,    26'h0,  32'h204, 0, 32'h0,   6, 3, 1, 0));
        tbl.push_back(mk(3'd4, 1, 0, 1, 0, 32'h0,   16'h0,    26'h10, 32'h040, 1, 32'h208, 6, 3, 1, 0));
        tbl.push_back(mk(3'd0, 1, 0, 0, 1, 32'h0,   16'h0,    26'h0,  32'h040, 0, 32'h0,   6, 3, 1, 0));

        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].src, tbl[i].ih, tbl[i].dh, tbl[i].en, tbl[i].fl,
                  tbl[i].rd, tbl[i].imm, tbl[i].imm26);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.pc", i),    imemaddr, tbl[i].e_pc);
            chk($sformatf("vec%0d.count", i), 32'(ras_count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.top", i),   ras_top, tbl[i].e_top);
            chk($sformatf("vec%0d.hit", i),   32'(ras_hit_cnt), 32'(tbl[i].e_hit));
            chk($sformatf("vec%0d.miss", i),  32'(ras_miss_cnt), 32'(tbl[i].e_miss));
            chk($sformatf("vec%0d.ovf", i),   32'(ras_overflow), 32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d.unf", i),   32'(ras_underflow), 32'(tbl[i].e_unf));
        end

        // push once more so the async reset has stack state to discard
        drive(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 26'h20);
        step("pre_rst");
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        #3 nRST = 1'b0;
        #1;
        model_reset();
        chk("async_rst.pc",    imemaddr, PC_INIT);
        chk("async_rst.count", 32'(ras_count), 32'd0);
        chk("async_rst.top",   ras_top, 32'd0);
        chk("async_rst.ovf",   32'(ras_overflow), 32'd0);
        #2 nRST = 1'b1;
        @(posedge CLK);
        #1;
        compare_model("post_rst");

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            PCSrc       = (r == 8) ? 3'd4 : (r == 9) ? 3'd5 : 3'(r);
            ihit        = ($urandom_range(0, 9) < 8);
            dhit        = ($urandom_range(0, 9) < 1);
            pc_en       = ($urandom_range(0, 9) < 9);
            ras_flush   = ($urandom_range(0, 29) == 0);
            immediate   = 16'($urandom);
            immediate26 = 26'($urandom);
            if (m_q.size() > 0 && $urandom_range(0, 1) == 1) rdat1 = m_q[$];
            else rdat1 = $urandom;
            step($sformatf("rnd%0d", i));
        end
        chk("rnd.miss_saturated", 32'(ras_miss_cnt), 32'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program-counter unit for the MIPS datapath. It generates the instruction fetch address from the selected next-PC source. It adds a circular return-address stack (RAS): JAL pushes the link address, and JR-return pops it to check prediction accuracy. Saturating hit/miss counters and overflow/underflow status support performance analysis. It sits between the control unit/register file and the instruction memory address port.

Parameters:
PC_INIT, 32'h00000000, address loaded into the PC on reset
RAS_DEPTH, 4, number of RAS entries (power of two, 2..16)
CNT_W, 16, width of the RAS hit/miss counters

Ports:
CLK  input  1  system clock, rising-edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction memory hit
dhit  input  1  data memory hit (stalls PC this cycle)
pc_en  input  1  control-unit PC enable
PCSrc  input  3  next-PC select (encoding below)
rdat1  input  32  register rs value (JR target)
immediate  input  16  branch offset (word count, signed)
immediate26  input  26  jump target field
ras_flush  input  1  clear RAS pointer/count (e.g. context switch)
imemaddr  output  32  current PC / fetch address
pc_plus4  output  32  imemaddr + 4 (link value)
ras_top  output  32  current top-of-stack entry (0 when empty)
ras_count  output  $clog2(RAS_DEPTH)+1  valid entries
ras_hit_cnt  output  CNT_W  saturating count of correct return predictions
ras_miss_cnt  output  CNT_W  saturating count of mispredictions plus empty pops
ras_overflow  output  1  sticky: a push occurred while full
ras_underflow  output  1  one-cycle pulse: pop attempted while empty

Behaviour:
- Interface: one clock CLK; nRST is asynchronous and active-low. All state resets on nRST low, independent of CLK.
- Reset values: imemaddr=PC_INIT; ras_count=0; all RAS entries=0; hit/miss counters=0; ras_overflow=0; ras_underflow=0.
- advance = pc_en & ihit & ~dhit. PC and RAS change only on a CLK rising edge with advance=1. Otherwise everything holds, except that ras_underflow clears and ras_flush still applies.
- Next-PC arithmetic uses base = pc_plus4 = imemaddr+4, computed mod 2^32:
  - 0 SEQ: base
  - 1 BR: base + (sign-extend(immediate) << 2)
  - 2 J: {base[31:28], immediate26, 2'b00}
  - 3 JR: rdat1; no RAS action
  - 4 JAL: J target; push base
  - 5 RET: rdat1; pop
  - 6, 7: treated as SEQ
- Latency: the new PC is visible on imemaddr one cycle after the advancing edge. There is no bypass.
- RAS storage: circular buffer with top pointer tp.
  - Push: entry[tp+1] <= base; tp <= tp+1 (wraps modulo RAS_DEPTH).
  - Push when full: overwrites the oldest entry, count stays RAS_DEPTH, ras_overflow <= 1 (sticky until reset).
  - Pop with count>0: compare entry[tp] with rdat1. Equal: ras_hit_cnt++. Not equal: ras_miss_cnt++. Then tp--, count--. The PC still takes rdat1 (rdat1 is authoritative).
  - Pop with count=0: ras_miss_cnt++, ras_underflow pulses high for one cycle, tp unchanged.
- Counters saturate at 2^CNT_W-1 and never wrap.
- ras_top = entry[tp] when count>0, else 0 (combinational).
- ras_flush: count <= 0 and tp <= 0 on the next edge. Flush has priority over a same-cycle push/pop, which is discarded. The PC still advances. Entries, counters and ras_overflow are not cleared.
- Stall with PCSrc=4/5 held over several cycles causes exactly one push/pop, on the single advancing edge.
- Reset asserted mid-operation: imemaddr returns to PC_INIT immediately (asynchronously). The RAS empties.

Test Plan:
- Reset/SEQ: PC_INIT=0; release nRST, hold ihit=1, PCSrc=0 for 3 cycles -> imemaddr 0,4,8,C. Drop ihit for 2 cycles -> holds C.
- Branch/jump: at PC=0x10, BR with immediate=16'hFFFC -> 0x04. At PC=0x04, J with immediate26=0x40 -> 0x100. At PC=0x100, dhit=1 -> PC stays 0x100.
- Call/return hit: at PC=0x20, JAL with immediate26=0x80 -> PC 0x200, ras_top=0x24, ras_count=1. Then RET with rdat1=0x24 -> PC 0x24, ras_hit_cnt=1, ras_count=0.
- Mispredict/underflow: RET with empty stack, rdat1=0x50 -> PC 0x50, ras_miss_cnt=1, ras_underflow high for exactly one cycle. Push 0x24, then RET with rdat1=0x28 -> ras_miss_cnt=2.
- Overflow: 5 JALs with RAS_DEPTH=4 -> ras_count=4, ras_overflow=1. Four RETs pop the last 4 links in LIFO order; a 5th RET underflows.
- Flush/reset: ras_flush together with JAL -> PC jumps, ras_count=0. Assert nRST between edges -> imemaddr=PC_INIT with no clock edge.
